// File: rtl/pipo_share_arbiter_pkg.sv
// Shared definitions for the two-requester shared PIPO register block.
//   state_t : FSM encoding (IDLE = capture possible, HOLD = word being presented)
//   CNT_W   : width of the hold-cycle down-counter
package pipo_share_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pipo_share_arbiter_if.sv
// Handshake/bus bundle between two producers, the shared register and its consumer.
//   req0/data0, req1/data1 : requester words (driven by the producer side)
//   gnt0/gnt1              : one-cycle capture acknowledge per requester
//   reg_out/reg_valid      : shared register contents and presentation flag
//   owner                  : requester index whose word sits in reg_out
//   busy                   : high while a captured word is being held
// master = producer/consumer side, slave = the arbiter.
interface pipo_share_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] reg_out;
  logic             reg_valid;
  logic             owner;
  logic             busy;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, reg_out, reg_valid, owner, busy
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, reg_out, reg_valid, owner, busy
  );
endinterface

// File: rtl/pipo_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
//   req0, req1  : pending requests
//   last_winner : index granted most recently
//   win_valid   : at least one request pending
//   win_idx     : chosen requester (the one that did not win last on a tie)
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic win_valid,
  output logic win_idx
);

  always_comb begin
    win_valid = req0 | req1;
    if (req0 && req1) begin
      win_idx = ~last_winner;
    end else begin
      win_idx = req1;
    end
  end

endmodule

// File: rtl/pipo_share_arbiter.sv
// Shares one WIDTH-bit parallel register between two requesters. A round-robin
// winner's word is captured, presented for HOLD_CYCLES cycles, then the block
// re-arbitrates. All outputs are registered.
//   clk : rising-edge clock
//   rst : synchronous reset, active low
//   bus : slave side of pipo_share_arbiter_if (requests, grants, shared word)
module pipo_share_arbiter
  import pipo_share_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipo_share_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_winner;
  logic [WIDTH-1:0] r_reg;
  logic             r_valid;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_owner;
  logic             r_busy;

  logic             w_win_valid;
  logic             w_win_idx;
  logic [WIDTH-1:0] w_win_data;

  rr_arb2 u_arb (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_winner (r_last_winner),
    .win_valid   (w_win_valid),
    .win_idx     (w_win_idx)
  );

  assign w_win_data = w_win_idx ? bus.data1 : bus.data0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_last_winner <= 1'b1;
      r_reg         <= '0;
      r_valid       <= 1'b0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_owner       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_reg         <= w_win_data;
            r_gnt0        <= ~w_win_idx;
            r_gnt1        <= w_win_idx;
            r_owner       <= w_win_idx;
            r_last_winner <= w_win_idx;
            r_valid       <= 1'b1;
            r_busy        <= 1'b1;
            r_cnt         <= HOLD_LOAD;
            r_state       <= ST_HOLD;
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Requests are ignored here; the word stays frozen until the count expires.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.reg_out   = r_reg;
  assign bus.reg_valid = r_valid;
  assign bus.owner     = r_owner;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Bench for pipo_share_arbiter: instance A uses HOLD_CYCLES=2, instance B uses
// HOLD_CYCLES=1. A transaction-level model tracks remaining presentation cycles.
module tb_pipo_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipo_share_arbiter_if #(.WIDTH(4)) a_if ();
  pipo_share_arbiter_if #(.WIDTH(4)) b_if ();

  pipo_share_arbiter #(.WIDTH(4), .HOLD_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  pipo_share_arbiter #(.WIDTH(4), .HOLD_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = instance A, 1 = instance B
  int         m_hold [2] = '{2, 1};
  int         m_rem  [2];
  logic [3:0] m_reg  [2];
  logic       m_gnt0 [2];
  logic       m_gnt1 [2];
  logic       m_owner[2];
  logic       m_last [2];

  function automatic logic [8:0] exp_vec(int k);
    return {m_gnt0[k], m_gnt1[k], m_reg[k], m_rem[k] > 0, m_owner[k], m_rem[k] > 0};
  endfunction

  function automatic logic [8:0] act_a();
    return {a_if.gnt0, a_if.gnt1, a_if.reg_out, a_if.reg_valid, a_if.owner, a_if.busy};
  endfunction

  function automatic logic [8:0] act_b();
    return {b_if.gnt0, b_if.gnt1, b_if.reg_out, b_if.reg_valid, b_if.owner, b_if.busy};
  endfunction

  task automatic model_edge(int k, logic r0, logic [3:0] d0, logic r1, logic [3:0] d1);
    logic win;
    if (!rst) begin
      m_rem[k] = 0; m_reg[k] = '0; m_gnt0[k] = 0; m_gnt1[k] = 0;
      m_owner[k] = 0; m_last[k] = 1;
    end else begin
      m_gnt0[k] = 0; m_gnt1[k] = 0;
      if (m_rem[k] > 0) begin
        m_rem[k] = m_rem[k] - 1;
      end else if (r0 || r1) begin
        win = (r0 && r1) ? ~m_last[k] : r1;
        m_reg[k]   = win ? d1 : d0;
        m_gnt0[k]  = ~win;
        m_gnt1[k]  = win;
        m_owner[k] = win;
        m_last[k]  = win;
        m_rem[k]   = m_hold[k];
      end
    end
  endtask

  // One clock edge; outputs settle and are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0, a_if.req0, a_if.data0, a_if.req1, a_if.data1);
    model_edge(1, b_if.req0, b_if.data0, b_if.req1, b_if.data1);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.req0 = 0; a_if.req1 = 0; a_if.data0 = '0; a_if.data1 = '0;
    b_if.req0 = 0; b_if.req1 = 0; b_if.data0 = '0; b_if.data1 = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    step();
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      a_if.req0 = 1'($urandom); a_if.req1 = 1'($urandom);
      a_if.data0 = 4'($urandom); a_if.data1 = 4'($urandom);
      b_if.req0 = 1'($urandom); b_if.req1 = 1'($urandom);
      b_if.data0 = 4'($urandom); b_if.data1 = 4'($urandom);
      step();
      n_checks++;
      if (act_a() !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_a cycle %0d: got %b expected %b", i, act_a(), 9'b0);
      end
      n_checks++;
      if (act_b() !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_b cycle %0d: got %b expected %b", i, act_b(), 9'b0);
      end
    end
    rst = 1;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    a_if.req0 = 1; a_if.data0 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_if.gnt0) a_if.req0 = 0;
      n_checks++;
      if (act_a() !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL single cycle %0d: got %b expected %b", i, act_a(), exp_vec(0));
      end
    end
    n_checks++;
    if (a_if.reg_out !== 4'b1101) begin
      n_fail++;
      $display("FAIL single_hold_value: got %b expected 1101", a_if.reg_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] caps[$];
    logic       owners[$];
    do_reset();
    a_if.req0 = 1; a_if.data0 = 4'b0110;
    a_if.req1 = 1; a_if.data1 = 4'b1001;
    for (int i = 0; i < 9; i++) begin
      step();
      if (a_if.gnt0 || a_if.gnt1) begin
        caps.push_back(a_if.reg_out);
        owners.push_back(a_if.owner);
      end
      n_checks++;
      if (act_a() !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got %b expected %b", i, act_a(), exp_vec(0));
      end
    end
    n_checks++;
    if (caps.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 3", caps.size());
    end else begin
      n_checks++;
      if (caps[0] !== 4'b0110 || caps[1] !== 4'b1001 || caps[2] !== 4'b0110 ||
          owners[0] !== 1'b0 || owners[1] !== 1'b1 || owners[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_order: got %b/%b/%b owners %b%b%b expected 0110/1001/0110 owners 010",
                 caps[0], caps[1], caps[2], owners[0], owners[1], owners[2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_req1_first();
    logic seen;
    do_reset();
    a_if.req1 = 1; a_if.data1 = 4'b1001;
    step();
    n_checks++;
    if (a_if.gnt1 !== 1'b1 || a_if.owner !== 1'b1 || a_if.reg_out !== 4'b1001) begin
      n_fail++;
      $display("FAIL req1_first: got gnt1=%b owner=%b reg=%b expected 1 1 1001",
               a_if.gnt1, a_if.owner, a_if.reg_out);
    end
    a_if.req0 = 1; a_if.data0 = 4'($urandom);
    a_if.data1 = 4'($urandom);
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      n_checks++;
      if (act_a() !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL req1_then_both cycle %0d: got %b expected %b", i, act_a(), exp_vec(0));
      end
      if (a_if.gnt0 || a_if.gnt1) begin
        seen = 1;
        n_checks++;
        if (a_if.owner !== 1'b0 || a_if.gnt0 !== 1'b1 || a_if.reg_out !== a_if.data0) begin
          n_fail++;
          $display("FAIL req1_then_req0_wins: got owner=%b gnt0=%b reg=%b expected 0 1 %b",
                   a_if.owner, a_if.gnt0, a_if.reg_out, a_if.data0);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL req1_then_both_timeout: got no grant expected grant within 6 cycles");
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    a_if.req0 = 1; a_if.data0 = 4'b0110;
    a_if.req1 = 1; a_if.data1 = 4'b1001;
    step();
    step();
    rst = 0;
    step();
    n_checks++;
    if (act_a() !== 9'b0) begin
      n_fail++;
      $display("FAIL mid_hold_reset: got %b expected %b", act_a(), 9'b0);
    end
    rst = 1;
    step();
    n_checks++;
    if (act_a() !== exp_vec(0) || a_if.gnt0 !== 1'b1 || a_if.owner !== 1'b0 ||
        a_if.reg_out !== 4'b0110) begin
      n_fail++;
      $display("FAIL mid_hold_restart: got %b expected %b", act_a(), exp_vec(0));
    end
    idle_inputs();
  endtask

  task automatic test_hold_one();
    int gnts, valids;
    do_reset();
    b_if.req0 = 1; b_if.data0 = 4'($urandom);
    b_if.req1 = 1; b_if.data1 = 4'($urandom);
    gnts = 0; valids = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b_if.gnt0) b_if.data0 = 4'($urandom);
      if (b_if.gnt1) b_if.data1 = 4'($urandom);
      if (b_if.gnt0 || b_if.gnt1) gnts++;
      if (b_if.reg_valid) valids++;
      n_checks++;
      if (act_b() !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL hold1 cycle %0d: got %b expected %b", i, act_b(), exp_vec(1));
      end
    end
    n_checks++;
    if (gnts != 5 || valids != 5) begin
      n_fail++;
      $display("FAIL hold1_rate: got %0d grants %0d valid cycles expected 5 and 5", gnts, valids);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (act_a() !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b", i, act_a(), exp_vec(0));
      end
      // Producers follow the protocol: on grant drop or present a new word.
      if (a_if.req0 && m_gnt0[0]) begin
        a_if.req0 = 1'($urandom); a_if.data0 = 4'($urandom);
      end else if (!a_if.req0 && $urandom_range(0, 9) < 3) begin
        a_if.req0 = 1; a_if.data0 = 4'($urandom);
      end
      if (a_if.req1 && m_gnt1[0]) begin
        a_if.req1 = 1'($urandom); a_if.data1 = 4'($urandom);
      end else if (!a_if.req1 && $urandom_range(0, 9) < 3) begin
        a_if.req1 = 1; a_if.data1 = 4'($urandom);
      end
    end
    rst = 1;
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_reg[k] = '0; m_gnt0[k] = 0; m_gnt1[k] = 0;
      m_owner[k] = 0; m_last[k] = 1;
    end
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_req1_first();
    test_reset_mid_hold();
    test_hold_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
